// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the FIFO family and its stream adapters.
package fifo_pkg;

   localparam int DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2
   } unpack_state_e;

   function automatic int unpack_ratio(input int in_w, input int out_w);
      return in_w / out_w;
   endfunction

   // Never narrower than one bit so an illegal ratio still elaborates far enough to report itself.
   function automatic int unpack_cnt_width(input int in_w, input int out_w);
      int w;
      w = $clog2(in_w / out_w);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/fifo_unpacker.sv
// Drains words from a FIFO read port and serialises each into OUT_WIDTH-bit slices
// on a valid/ready stream, flagging the final slice of every word with out_last.
module fifo_unpacker
   import fifo_pkg::*;
#(
   parameter int IN_WIDTH  = DATA_WIDTH,
   parameter int OUT_WIDTH = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 fifo_empty,
   output logic                 fifo_rd_en,
   input  logic [IN_WIDTH-1:0]  fifo_rd_data,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last
);

   localparam int RATIO = unpack_ratio(IN_WIDTH, OUT_WIDTH);
   localparam int CNT_W = unpack_cnt_width(IN_WIDTH, OUT_WIDTH);

   if (RATIO < 2 || (IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_ratio
      $error("fifo_unpacker: IN_WIDTH must be an integer multiple (>= 2) of OUT_WIDTH");
   end

   unpack_state_e       state_reg, state_next;
   logic [CNT_W-1:0]    cnt_reg;
   logic [IN_WIDTH-1:0] shift_reg;
   logic                last_slice;

   assign last_slice = (cnt_reg == CNT_W'(RATIO - 1));
   assign out_data   = LSB_FIRST ? shift_reg[OUT_WIDTH-1:0]
                                 : shift_reg[IN_WIDTH-1 -: OUT_WIDTH];

   // Outputs are masked during reset so no slice or read can slip through the reset cycle.
   always_comb begin
      state_next = state_reg;
      fifo_rd_en = 1'b0;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      case (state_reg)
         IDLE: begin
            fifo_rd_en = !fifo_empty && !reset;
            if (!fifo_empty) state_next = FETCH;
         end
         FETCH: state_next = SEND;
         SEND: begin
            out_valid = !reset;
            out_last  = last_slice && !reset;
            if (out_ready && last_slice) begin
               if (!fifo_empty) begin
                  fifo_rd_en = !reset;
                  state_next = FETCH;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            FETCH: begin
               shift_reg <= fifo_rd_data;
               cnt_reg   <= '0;
            end
            SEND: begin
               if (out_ready) begin
                  if (LSB_FIRST) shift_reg <= shift_reg >> OUT_WIDTH;
                  else           shift_reg <= shift_reg << OUT_WIDTH;
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
